// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if -- stream bundle between N_CH producers, the mux and one consumer.
//   up_valid/up_data/up_ready : per-channel producer handshake (up_data[i] = channel i)
//   down_valid/down_data/down_ch/down_ready : merged consumer handshake
//   up_last/down_last : packet delimiters, present only with RR_STREAM_MUX_LOCK_EN
// Modports: master = producer/consumer environment, slave = the mux.
interface rr_stream_mux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]        up_valid;
  logic [N_CH-1:0][W-1:0] up_data;
  logic [N_CH-1:0]        up_ready;
  logic                   down_valid;
  logic [W-1:0]           down_data;
  logic [CW-1:0]          down_ch;
  logic                   down_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
  logic [N_CH-1:0]        up_last;
  logic                   down_last;

  modport master (output up_valid, up_data, up_last, down_ready,
                  input  up_ready, down_valid, down_data, down_ch, down_last);
  modport slave  (input  up_valid, up_data, up_last, down_ready,
                  output up_ready, down_valid, down_data, down_ch, down_last);
`else
  modport master (output up_valid, up_data, down_ready,
                  input  up_ready, down_valid, down_data, down_ch);
  modport slave  (input  up_valid, up_data, down_ready,
                  output up_ready, down_valid, down_data, down_ch);
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux -- N_CH-to-1 round-robin stream mux with a single registered output slot.
// Ports:
//   clk  : clock, everything on posedge
//   rst  : synchronous reset, active low
//   bus  : rr_stream_mux_if.slave (up_* per-channel inputs, down_* merged output)
// Optional feature (macro RR_STREAM_MUX_LOCK_EN): packet lock. Once a channel is
//   granted it keeps the grant until a beat with up_last set is accepted;
//   down_last travels with the beat.
module rr_stream_mux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_stream_mux_if.slave  bus
);
  localparam int            CW      = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  logic          dv_q;
  logic [W-1:0]  dd_q;
  logic [CW-1:0] dch_q;
  logic [CW-1:0] last_q;   // most recently served channel

  logic          load_en;
  logic          gnt_vld;
  logic [CW-1:0] gnt;
  logic [CW-1:0] cand;
  logic [N_CH-1:0] req;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic          lock_q;
  logic [CW-1:0] lock_ch_q;
  logic          dl_q;

  // While a packet is open only its owner may request, even if it is idle.
  always_comb begin
    req = bus.up_valid;
    if (lock_q) req = bus.up_valid & (N_CH'(1) << lock_ch_q);
  end
`else
  assign req = bus.up_valid;
`endif

  // Slot can take a beat when empty or being drained this cycle.
  assign load_en = !dv_q || bus.down_ready;

  // Scan last+1, last+2, ... wrapping at N_CH; first requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = (int'(last_q) + k >= N_CH) ? CW'(int'(last_q) + k - N_CH)
                                        : CW'(int'(last_q) + k);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held.
  for (genvar i = 0; i < N_CH; i++) begin : g_rdy
    assign bus.up_ready[i] = rst && load_en && gnt_vld && (gnt == CW'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_q   <= 1'b0;
      dd_q   <= '0;
      dch_q  <= '0;
      last_q <= LAST_CH;
    end else if (load_en) begin
      dv_q <= gnt_vld;
      if (gnt_vld) begin
        dd_q   <= bus.up_data[gnt];
        dch_q  <= gnt;
        last_q <= gnt;
      end
    end
  end

`ifdef RR_STREAM_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      dl_q      <= 1'b0;
    end else if (load_en && gnt_vld) begin
      dl_q      <= bus.up_last[gnt];
      lock_q    <= !bus.up_last[gnt];
      lock_ch_q <= gnt;
    end
  end

  assign bus.down_last = dl_q;
`endif

  assign bus.down_valid = dv_q;
  assign bus.down_data  = dd_q;
  assign bus.down_ch    = dch_q;
endmodule
